// File: rtl/bt656_pkg.sv
// Shared constants for the BT.656 capture path: default geometry, XY bit positions, FSM encoding.
// Optional build macro BT656_PROTECTION_CHECK_EN enables the XY protection-bit check (uses trs_prot).
package bt656_pkg;

    localparam int unsigned ACTIVE_WORDS_DEF = 720;
    localparam int unsigned FIELD_LINES_DEF  = 288;
    localparam logic [19:0] FIELD_BASE_DEF   = 20'h32A00;
    localparam int unsigned LINE_BYTES       = 1440;

    localparam int XY_ONE = 7;
    localparam int XY_F   = 6;
    localparam int XY_V   = 5;
    localparam int XY_H   = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ARM    = 3'd1;
    localparam logic [2:0] ST_BLANK  = 3'd2;
    localparam logic [2:0] ST_ACTIVE = 3'd3;
    localparam logic [2:0] ST_HBLANK = 3'd4;

    // Expected XY[3:0] for a given F/V/H
    function automatic logic [3:0] trs_prot(input logic f, input logic v, input logic h);
        return {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

endpackage

// File: rtl/bt656_trs_decoder.sv
// Timing-reference (FF 00 00 XY) parser; flags malformed codes on sync_err.
// With BT656_PROTECTION_CHECK_EN defined, XY[3:0] must match the protection bits.
module bt656_trs_decoder
    import bt656_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    output logic       code_valid,
    output logic       f,
    output logic       v,
    output logic       h,
    output logic       sync_err,
    output logic       in_trs
);

    localparam logic [1:0] SEARCH  = 2'd0;
    localparam logic [1:0] GOT_FF  = 2'd1;
    localparam logic [1:0] GOT_00A = 2'd2;
    localparam logic [1:0] GOT_00B = 2'd3;

    logic [1:0] state;
    logic       prot_ok;

    assign f      = din[XY_F];
    assign v      = din[XY_V];
    assign h      = din[XY_H];
    assign in_trs = (state != SEARCH);

`ifdef BT656_PROTECTION_CHECK_EN
    assign prot_ok = (din[3:0] == trs_prot(f, v, h));
`else
    assign prot_ok = 1'b1;
`endif

    always_comb begin
        code_valid = 1'b0;
        sync_err   = 1'b0;
        case (state)
            GOT_FF, GOT_00A: sync_err = (din != 8'h00);
            GOT_00B: begin
                code_valid = din[XY_ONE] && prot_ok;
                sync_err   = !(din[XY_ONE] && prot_ok);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SEARCH;
        end else begin
            case (state)
                SEARCH:  state <= (din == 8'hFF) ? GOT_FF : SEARCH;
                GOT_FF:  state <= (din == 8'h00) ? GOT_00A : SEARCH;
                GOT_00A: state <= (din == 8'h00) ? GOT_00B : SEARCH;
                default: state <= SEARCH;
            endcase
        end
    end

endmodule

// File: rtl/bt656_sram_writer.sv
// Captures BT.656 frames into an async SRAM as 16-bit {Y,C} words, one write per Y byte.
// Build macro BT656_PROTECTION_CHECK_EN (in the decoder) rejects codes with bad protection bits.
module bt656_sram_writer
    import bt656_pkg::*;
#(
    parameter int unsigned ACTIVE_WORDS = ACTIVE_WORDS_DEF,
    parameter int unsigned FIELD_LINES  = FIELD_LINES_DEF,
    parameter logic [19:0] FIELD_BASE   = FIELD_BASE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  qd,
    input  logic        capture_en,
    output logic [19:0] sram_addr,
    output logic [15:0] sram_data,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        capturing,
    output logic        capture_done,
    output logic        sync_err,
    output logic        field
);

    localparam int          LW        = $clog2(FIELD_LINES + 1);
    localparam logic [LW-1:0] LINE_MAX = LW'(FIELD_LINES);
    localparam logic [10:0] BYTE_LAST = 11'(LINE_BYTES - 1);
    localparam logic [10:0] WORDS     = 11'(ACTIVE_WORDS);

    logic [7:0]    qd_r;
    logic          code_valid, cf, cv, ch, dec_err, in_trs;
    logic [2:0]    state;
    logic [LW-1:0] line_cnt;
    logic [10:0]   byte_cnt;
    logic [9:0]    word_idx;
    logic          full, seen_f1;
    logic [7:0]    c_lat;
    logic [19:0]   wr_addr;
    logic          in_frame, data_ok, wr_ok, frame_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) qd_r <= 8'h00;
        else      qd_r <= qd;
    end

    bt656_trs_decoder u_trs (
        .clk        (clk),
        .rst        (rst),
        .din        (qd_r),
        .code_valid (code_valid),
        .f          (cf),
        .v          (cv),
        .h          (ch),
        .sync_err   (dec_err),
        .in_trs     (in_trs)
    );

    assign in_frame  = (state == ST_BLANK) || (state == ST_ACTIVE) || (state == ST_HBLANK);
    assign capturing = in_frame;
    assign sram_ce_n = !in_frame;
    assign sram_oe_n = 1'b1;

    assign word_idx  = byte_cnt[10:1];
    assign wr_addr   = (field ? FIELD_BASE : 20'd0)
                     + 20'(line_cnt) * 20'(ACTIVE_WORDS) + 20'(word_idx);
    assign frame_end = code_valid && !cf && cv && seen_f1;

    // TRS bytes and FF never count as pixels; 'full' stops a rewrite of the last word past byte 1439
    assign data_ok = (state == ST_ACTIVE) && !in_trs && (qd_r != 8'hFF) && !full;
    assign wr_ok   = data_ok && byte_cnt[0] && ({1'b0, word_idx} < WORDS) && (line_cnt < LINE_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            line_cnt     <= '0;
            byte_cnt     <= '0;
            full         <= 1'b0;
            seen_f1      <= 1'b0;
            c_lat        <= 8'h00;
            sram_addr    <= 20'd0;
            sram_data    <= 16'd0;
            sram_we_n    <= 1'b1;
            capture_done <= 1'b0;
            sync_err     <= 1'b0;
            field        <= 1'b0;
        end else begin
            sync_err     <= dec_err;
            capture_done <= 1'b0;
            sram_we_n    <= 1'b1;

            if (code_valid) begin
                field <= cf;
                if (cv) line_cnt <= '0;
            end

            if (data_ok) begin
                if (byte_cnt == BYTE_LAST) full <= 1'b1;
                else                       byte_cnt <= byte_cnt + 11'd1;
                if (!byte_cnt[0]) c_lat <= qd_r;
            end

            if (wr_ok) begin
                sram_we_n <= 1'b0;
                sram_addr <= wr_addr;
                sram_data <= {qd_r, c_lat};
            end

            case (state)
                ST_IDLE: if (capture_en) state <= ST_ARM;
                ST_ARM:  if (code_valid && !cf && cv) state <= ST_BLANK;
                ST_BLANK, ST_ACTIVE, ST_HBLANK: begin
                    if (frame_end) begin
                        capture_done <= 1'b1;
                        seen_f1      <= 1'b0;
                        state        <= capture_en ? ST_ARM : ST_IDLE;
                    end else if (state != ST_ACTIVE && code_valid && !ch && !cv) begin
                        state    <= ST_ACTIVE;
                        byte_cnt <= '0;
                        full     <= 1'b0;
                        if (cf) seen_f1 <= 1'b1;
                    end else if (state == ST_ACTIVE && code_valid && ch) begin
                        // Only the EAV closing an active line advances the line
                        state <= ST_HBLANK;
                        if (!cv && line_cnt != LINE_MAX) line_cnt <= line_cnt + LW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bt656_sram_writer.sv
// Self-checking bench: TRS decode table, scoreboarded frame capture, corner-case sequences.
module tb_bt656_sram_writer;

    localparam int          AW = 720;
    localparam int          FL = 4;
    localparam logic [19:0] FB = 20'h32A00;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  qd = 8'h10;
    logic        capture_en = 1'b0;
    logic [19:0] sram_addr;
    logic [15:0] sram_data;
    logic        sram_ce_n, sram_oe_n, sram_we_n;
    logic        capturing, capture_done, sync_err, field;

    bt656_sram_writer #(.ACTIVE_WORDS(AW), .FIELD_LINES(FL), .FIELD_BASE(FB)) dut (
        .clk          (clk),
        .rst          (rst),
        .qd           (qd),
        .capture_en   (capture_en),
        .sram_addr    (sram_addr),
        .sram_data    (sram_data),
        .sram_ce_n    (sram_ce_n),
        .sram_oe_n    (sram_oe_n),
        .sram_we_n    (sram_we_n),
        .capturing    (capturing),
        .capture_done (capture_done),
        .sync_err     (sync_err),
        .field        (field)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0, n_total = 0;
    int err_cnt = 0, done_cnt = 0;

    typedef struct { logic [19:0] addr; logic [15:0] data; int due; } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    typedef struct { logic [31:0] bytes; int err; logic fld; } vec_t;
    vec_t tv[9];
    logic [7:0] pat38 [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard: every write strobe must match the head of the expected queue
    always @(negedge clk) begin
        if (rst) begin
            if (sync_err) err_cnt++;
            if (capture_done) done_cnt++;
            if (!sram_we_n) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_write: addr %0h data %0h, no write expected", sram_addr, sram_data);
                end else begin
                    mon_e = sb.pop_front();
                    chk("wr_addr", 64'(sram_addr), 64'(mon_e.addr));
                    chk("wr_data", 64'(sram_data), 64'(mon_e.data));
                    chk("wr_cycle", 64'(cyc), 64'(mon_e.due));
                end
            end
        end
    end

    task automatic put(input logic [7:0] b);
        @(posedge clk);
        #1 qd = b;
    endtask

    task automatic fill(input int n);
        repeat (n) put(8'h10);
    endtask

    task automatic trs(input logic f, input logic v, input logic h);
        logic [7:0] xy;
        xy = {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
        put(8'hFF); put(8'h00); put(8'h00); put(xy);
    endtask

    task automatic vblank(input logic f);
        trs(f, 1'b1, 1'b1); fill(4);
        trs(f, 1'b1, 1'b0); fill(4);
    endtask

    task automatic act_line(input logic f, input int line, input int nbytes, input bit expect_wr, input bit pat);
        logic [7:0] b, c;
        exp_t e;
        c = 8'h00;
        trs(f, 1'b0, 1'b0);
        for (int i = 0; i < nbytes; i++) begin
            if (pat)            b = pat38[i];
            else if (i % 2 == 0) b = 8'h20 + 8'((i / 2 + line * 3) % 100);
            else                b = 8'h90 + 8'((i / 2 + line * 13 + int'(f) * 7) % 100);
            put(b);
            if (i % 2 == 0) c = b;
            else if (expect_wr && (i / 2) < AW && line < FL) begin
                e.addr = (f ? FB : 20'd0) + 20'(line * AW + i / 2);
                e.data = {b, c};
                e.due  = cyc + 2;
                sb.push_back(e);
            end
        end
        trs(f, 1'b0, 1'b1);
        fill(4);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bb;
        int e0;

        pat38 = '{8'h80, 8'h10, 8'h80, 8'h20};
        tv[0] = '{32'hFF000080, 0, 1'b0};
        tv[1] = '{32'hFF0000C7, 0, 1'b1};
        tv[2] = '{32'hFF007F10, 1, 1'b1};
        tv[3] = '{32'hFF000040, 1, 1'b1};
        tv[4] = '{32'hFF101010, 1, 1'b1};
`ifdef BT656_PROTECTION_CHECK_EN
        tv[5] = '{32'hFF000081, 1, 1'b1};
`else
        tv[5] = '{32'hFF000081, 0, 1'b0};
`endif
        tv[6] = '{32'hFF00009D, 0, 1'b0};
        tv[7] = '{32'hFF0000DA, 0, 1'b1};
        tv[8] = '{32'hFFFF0000, 1, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_addr", 64'(sram_addr), 64'd0);
        chk("rst_data", 64'(sram_data), 64'd0);
        chk("rst_ce_n", 64'(sram_ce_n), 64'd1);
        chk("rst_oe_n", 64'(sram_oe_n), 64'd1);
        chk("rst_we_n", 64'(sram_we_n), 64'd1);
        chk("rst_capturing", 64'(capturing), 64'd0);
        chk("rst_done", 64'(capture_done), 64'd0);
        chk("rst_sync_err", 64'(sync_err), 64'd0);
        chk("rst_field", 64'(field), 64'd0);
        rst = 1'b1;
        fill(3);

        // Timing-reference decode table, capture idle
        for (int k = 0; k < 9; k++) begin
            bb = tv[k].bytes;
            e0 = err_cnt;
            put(bb[31:24]); put(bb[23:16]); put(bb[15:8]); put(bb[7:0]);
            fill(4);
            @(posedge clk);
            #2;
            chk($sformatf("trs%0d_err", k), 64'(err_cnt - e0), 64'(tv[k].err));
            chk($sformatf("trs%0d_field", k), 64'(field), 64'(tv[k].fld));
        end
        chk("idle_capturing", 64'(capturing), 64'd0);
        chk("idle_ce_n", 64'(sram_ce_n), 64'd1);

        // Frame 1: arm, sync error in blanking, full/short/pattern/suppressed lines
        capture_en = 1'b1;
        fill(2);
        chk("arm_not_capturing", 64'(capturing), 64'd0);
        vblank(1'b0);
        chk("blank_capturing", 64'(capturing), 64'd1);
        chk("blank_ce_n", 64'(sram_ce_n), 64'd0);
        e0 = err_cnt;
        put(8'hFF); put(8'h00); put(8'h7F);
        fill(3);
        chk("bad_trs_err", 64'(err_cnt - e0), 64'd1);
        chk("bad_trs_capturing", 64'(capturing), 64'd1);
        act_line(1'b0, 0, 1440, 1'b1, 1'b0);
        act_line(1'b0, 1, 1000, 1'b1, 1'b0);
        act_line(1'b0, 2, 1440, 1'b1, 1'b0);
        act_line(1'b0, 3, 4, 1'b1, 1'b1);
        act_line(1'b0, 4, 10, 1'b1, 1'b0);
        act_line(1'b0, 5, 10, 1'b1, 1'b0);
        fill(4);
        chk("field0_drained", 64'(sb.size()), 64'd0);
        vblank(1'b1);
        act_line(1'b1, 0, 1440, 1'b1, 1'b0);
        act_line(1'b1, 1, 20, 1'b1, 1'b0);
        fill(4);
        chk("field1_drained", 64'(sb.size()), 64'd0);
        chk("no_done_midframe", 64'(done_cnt), 64'd0);
        vblank(1'b0);
        fill(2);
        chk("frame1_done", 64'(done_cnt), 64'd1);
        chk("rearm_capturing", 64'(capturing), 64'd1);

        // Frame 2: capture_en dropped during field 1, frame still completes
        act_line(1'b0, 0, 10, 1'b1, 1'b0);
        act_line(1'b0, 1, 10, 1'b1, 1'b0);
        vblank(1'b1);
        act_line(1'b1, 0, 10, 1'b1, 1'b0);
        capture_en = 1'b0;
        act_line(1'b1, 1, 10, 1'b1, 1'b0);
        fill(2);
        chk("drop_en_still_capturing", 64'(capturing), 64'd1);
        vblank(1'b0);
        fill(2);
        chk("frame2_done", 64'(done_cnt), 64'd2);
        chk("end_capturing", 64'(capturing), 64'd0);
        chk("end_ce_n", 64'(sram_ce_n), 64'd1);
        chk("end_oe_n", 64'(sram_oe_n), 64'd1);
        chk("frame2_drained", 64'(sb.size()), 64'd0);
        act_line(1'b0, 0, 10, 1'b0, 1'b0);
        fill(4);
        chk("idle_no_done", 64'(done_cnt), 64'd2);

        // Reset asserted while a write strobe is active
        capture_en = 1'b1;
        fill(2);
        vblank(1'b0);
        trs(1'b0, 1'b0, 1'b0);
        put(8'h40);
        put(8'h95);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("we_before_reset", 64'(sram_we_n), 64'd0);
        rst = 1'b0;
        #1;
        chk("we_async_reset", 64'(sram_we_n), 64'd1);
        chk("ce_async_reset", 64'(sram_ce_n), 64'd1);
        chk("capturing_async_reset", 64'(capturing), 64'd0);
        capture_en = 1'b0;
        fill(3);
        rst = 1'b1;
        fill(4);
        chk("final_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bt656_sram_writer.md
BT656_SRAM_WRITER -- requirements
Module: bt656_sram_writer

Interface
REQ-001 Parameter ACTIVE_WORDS, default 720: 16-bit pixel words written per active line.
REQ-002 Parameter FIELD_LINES, default 288: maximum active lines written per field.
REQ-003 Parameter FIELD_BASE, default 20'h32A00: SRAM word offset of field 1.
REQ-004 clk  in  1  byte clock, 27 MHz BT.656 rate.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 qd  in  8  BT.656 byte stream from the video decoder.
REQ-007 capture_en  in  1  level; request to capture frames.
REQ-008 sram_addr  out  20  SRAM word address.
REQ-009 sram_data  out  16  write data; [15:8]=Y, [7:0]=C (Cb on even words, Cr on odd words).
REQ-010 sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM strobes, active-low.
REQ-011 capturing  out  1  high while a frame is being written.
REQ-012 capture_done  out  1  one-cycle pulse at the end of each captured frame.
REQ-013 sync_err  out  1  one-cycle pulse on a malformed timing reference.
REQ-014 field  out  1  F bit of the most recent valid timing code.

Function
REQ-015 The block SHALL register qd once; all decoding SHALL use the registered byte.
REQ-016 Parser states: SEARCH, GOT_FF, GOT_00A, GOT_00B; FF->GOT_FF; then 00->GOT_00A; then 00->GOT_00B; the next byte SHALL be taken as XY: F=XY[6], V=XY[5], H=XY[4].
REQ-017 A non-00 byte in GOT_FF or GOT_00A SHALL pulse sync_err and return to SEARCH; XY[7]=0 SHALL pulse sync_err and discard the code.
REQ-018 Capture FSM states: IDLE, ARM, BLANK, ACTIVE, HBLANK.
REQ-019 IDLE->ARM when capture_en=1; ARM->BLANK on a valid code with F=0,V=1 (start of frame).
REQ-020 BLANK->ACTIVE on SAV (H=0) with V=0; ACTIVE->HBLANK on EAV (H=1); HBLANK->ACTIVE on SAV with V=0.
REQ-021 A code with V=1 SHALL clear line_cnt; every EAV with V=0 SHALL increment line_cnt, saturating at FIELD_LINES.
REQ-022 At the first code with F=0,V=1 after any F=1 active line, the FSM SHALL pulse capture_done, go to ARM if capture_en=1, else IDLE.
REQ-023 Deasserting capture_en mid-frame SHALL NOT abort; the frame completes per REQ-022.
REQ-024 In ACTIVE, even bytes (byte_cnt[0]=0) SHALL be latched as C and odd bytes as Y; byte_cnt is 11-bit, cleared at SAV.
REQ-025 With Y on qd in cycle k, sram_addr/sram_data SHALL be valid and sram_we_n=0 in cycle k+2 for exactly one cycle.
REQ-026 sram_addr SHALL equal (F ? FIELD_BASE : 0) + line_cnt*ACTIVE_WORDS + word_idx, word_idx = byte_cnt>>1, computed in 20 bits.
REQ-027 Writes SHALL be suppressed when word_idx >= ACTIVE_WORDS or line_cnt >= FIELD_LINES; byte_cnt SHALL saturate at 1439.
REQ-028 An EAV arriving before 1440 bytes (short line) SHALL end the line with no further writes; the partial word is discarded.
REQ-029 sram_ce_n SHALL be 0 in BLANK/ACTIVE/HBLANK, else 1; sram_oe_n SHALL be constantly 1.
REQ-030 capturing SHALL be 1 in BLANK/ACTIVE/HBLANK.

Reset
REQ-031 On rst low: sram_addr=0, sram_data=0, sram_ce_n=1, sram_oe_n=1, sram_we_n=1, capturing=0, capture_done=0, sync_err=0, field=0, parser SEARCH, FSM IDLE, counters 0.
REQ-032 Reset mid-write SHALL deassert sram_we_n immediately (asynchronously).

Configuration
REQ-033 Macro BT656_PROTECTION_CHECK_EN: when defined, XY[3:0] SHALL be checked against P3=V^H, P2=F^H, P1=F^V, P0=F^V^H; a mismatch SHALL pulse sync_err and the code SHALL be ignored.
REQ-034 Without BT656_PROTECTION_CHECK_EN, XY[3:0] SHALL be ignored.

Structure
REQ-035 Package bt656_pkg SHALL hold ACTIVE_WORDS, FIELD_LINES, FIELD_BASE defaults, the 1440-byte line length, XY bit positions and the capture-FSM state encoding.
REQ-036 Sub-module bt656_trs_decoder SHALL contain the parser and protection check, emitting code_valid, F, V, H, sync_err.

Verification
REQ-037 capture_en=1, one PAL frame -> 720 writes per active line, field 0 line 0 word 0 at addr 0, field 1 line 0 word 0 at 0x32A00, one capture_done after frame.
REQ-038 Bytes 80,10,80,20 after SAV, line 3 field 0 -> writes 0x1080 at 2160, 0x2080 at 2161, we_n low one cycle each, two cycles after each Y.
REQ-039 Sequence FF,00,7F -> sync_err pulse, no state change, next valid SAV decoded normally.
REQ-040 EAV after 1000 bytes -> 500 writes that line, next line starts at word 0.
REQ-041 capture_en dropped at field-1 line 100 -> writes continue to frame end, capture_done pulses, FSM IDLE, ce_n=1.
REQ-042 With BT656_PROTECTION_CHECK_EN, XY=0x80 (correct 0x80) accepted; XY=0x81 -> sync_err, code ignored.
